// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// Holds the long-opcode nibble, the two-byte test, FSM states and FIFO entry.
package fetch_pkg;

    localparam int P_ADDR_W = 8;
    localparam int P_DATA_W = 8;

    // Opcodes whose high nibble matches this carry an immediate byte.
    localparam logic [3:0] LONG_NIB = 4'hC;

    typedef enum logic [1:0] {
        VEC_REQ,
        VEC_WAIT,
        RUN
    } fetch_state_e;

    typedef struct packed {
        logic [P_DATA_W-1:0] data;
        logic [P_ADDR_W-1:0] addr;
    } fifo_entry_t;

    function automatic logic is_two_byte(input logic [P_DATA_W-1:0] op);
        return op[P_DATA_W-1 -: 4] == LONG_NIB;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: memory port A, decode stall, redirect and IF/ID outputs.
// master = fetch unit side, slave = memory/decode/execute side.
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] instr_in;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ir_valid;
    logic [DATA_W-1:0] ir_opcode;
    logic [DATA_W-1:0] ir_imm;
    logic [ADDR_W-1:0] ir_pc;
    logic [ADDR_W-1:0] ir_next_pc;

    modport master (
        output addr_a, ir_valid, ir_opcode, ir_imm, ir_pc, ir_next_pc,
        input  instr_in, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  addr_a, ir_valid, ir_opcode, ir_imm, ir_pc, ir_next_pc,
        output instr_in, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit_byte_fifo.sv
// Byte buffer between memory responses and the IF/ID register.
// Ports: clk, rst, i_flush, i_push, i_push_data, i_pop1, i_pop2,
//        o_count, o_head (entry), o_head1_byte (byte after head).
module fetch_byte_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_flush,
    input  logic                i_push,
    input  fifo_entry_t         i_push_data,
    input  logic                i_pop1,
    input  logic                i_pop2,
    output logic [CW-1:0]       o_count,
    output fifo_entry_t         o_head,
    output logic [P_DATA_W-1:0] o_head1_byte
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_pop_n;
    fifo_entry_t   w_head1;

    // Modular pointer add so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(
        input logic [PW-1:0] p,
        input int            n
    );
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    assign w_pop_n = i_pop2 ? CW'(2) : (i_pop1 ? CW'(1) : CW'(0));
    assign w_head1 = r_mem[ptr_add(r_rd, 1)];

    assign o_count      = r_count;
    assign o_head       = r_mem[r_rd];
    assign o_head1_byte = w_head1.data;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= ptr_add(r_wr, 1);
            r_rd    <= ptr_add(r_rd, int'(w_pop_n));
            r_count <= r_count + CW'(i_push) - w_pop_n;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, memory port A requests, byte FIFO, IF/ID reg.
// Ports: clk, rst, io_bus (fetch_unit_if.master). Option: RESET_VECTOR_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = P_ADDR_W,
    parameter int                DATA_W     = P_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master io_bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_req_q;
    logic              r_ir_valid;
    logic [DATA_W-1:0] r_ir_opcode;
    logic [DATA_W-1:0] r_ir_imm;
    logic [ADDR_W-1:0] r_ir_pc;
    logic [ADDR_W-1:0] r_ir_next_pc;

    logic [CW-1:0]     w_count;
    fifo_entry_t       w_head;
    logic [DATA_W-1:0] w_head1;
    logic              w_run;
    logic              w_redir;
    logic              w_issue;
    logic              w_push;
    logic              w_load;
    logic              w_two;
    logic              w_pop1;
    logic              w_pop2;

`ifdef RESET_VECTOR_EN
    fetch_state_e r_state;
    assign w_run = (r_state == RUN);
`else
    assign w_run = 1'b1;
`endif

    // Redirects are only honoured once the reset vector has been loaded.
    assign w_redir = w_run && io_bus.redirect_valid;
    // Count the in-flight byte so a full FIFO never overflows.
    assign w_issue = w_run &&
                     (int'(w_count) + int'(r_req_q) < FIFO_DEPTH);
    assign w_push  = w_run && r_req_q && !w_redir;

    assign io_bus.addr_a = w_redir ? io_bus.redirect_pc : r_pc;

    assign w_load = !r_ir_valid || !io_bus.stall;
    assign w_two  = is_two_byte(w_head.data);
    assign w_pop1 = !w_redir && w_load && (w_count >= CW'(1)) && !w_two;
    assign w_pop2 = !w_redir && w_load && (w_count >= CW'(2)) && w_two;

    fetch_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (w_redir),
        .i_push       (w_push),
        .i_push_data  ({io_bus.instr_in, r_req_addr}),
        .i_pop1       (w_pop1),
        .i_pop2       (w_pop2),
        .o_count      (w_count),
        .o_head       (w_head),
        .o_head1_byte (w_head1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_q    <= 1'b0;
            r_req_addr <= '0;
`ifdef RESET_VECTOR_EN
            r_state    <= VEC_REQ;
            r_pc       <= '0;
`else
            r_pc       <= RESET_PC;
`endif
        end else begin
`ifdef RESET_VECTOR_EN
            unique case (r_state)
                VEC_REQ: begin
                    r_req_q    <= 1'b1;
                    r_req_addr <= r_pc;
                    r_state    <= VEC_WAIT;
                end
                VEC_WAIT: begin
                    r_pc    <= ADDR_W'(io_bus.instr_in);
                    r_req_q <= 1'b0;
                    r_state <= RUN;
                end
                default: begin
`endif
            if (w_redir) begin
                r_pc       <= io_bus.redirect_pc + ADDR_W'(1);
                r_req_q    <= 1'b1;
                r_req_addr <= io_bus.redirect_pc;
            end else if (w_issue) begin
                r_pc       <= r_pc + ADDR_W'(1);
                r_req_q    <= 1'b1;
                r_req_addr <= r_pc;
            end else begin
                r_req_q    <= 1'b0;
            end
`ifdef RESET_VECTOR_EN
                end
            endcase
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir_valid   <= 1'b0;
            r_ir_opcode  <= '0;
            r_ir_imm     <= '0;
            r_ir_pc      <= '0;
            r_ir_next_pc <= '0;
        end else if (w_redir) begin
            r_ir_valid <= 1'b0;
        end else if (w_load) begin
            if (w_pop1) begin
                r_ir_valid   <= 1'b1;
                r_ir_opcode  <= w_head.data;
                r_ir_imm     <= '0;
                r_ir_pc      <= w_head.addr;
                r_ir_next_pc <= w_head.addr + ADDR_W'(1);
            end else if (w_pop2) begin
                r_ir_valid   <= 1'b1;
                r_ir_opcode  <= w_head.data;
                r_ir_imm     <= w_head1;
                r_ir_pc      <= w_head.addr;
                r_ir_next_pc <= w_head.addr + ADDR_W'(2);
            end else begin
                r_ir_valid <= 1'b0;
            end
        end
    end

    assign io_bus.ir_valid   = r_ir_valid;
    assign io_bus.ir_opcode  = r_ir_opcode;
    assign io_bus.ir_imm     = r_ir_imm;
    assign io_bus.ir_pc      = r_ir_pc;
    assign io_bus.ir_next_pc = r_ir_next_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: byte memory model, program-order reference stream
// and directed scenarios (latency, long ops, stall, redirect, wrap, reset).
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] mem [256];

    int nvec = 0;
    int nerr = 0;

    fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    fetch_unit #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .RESET_PC   (8'h00),
        .FIFO_DEPTH (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Registered-read memory: byte for addr_a of cycle N shows in N+1.
    always @(posedge clk) bus.instr_in <= mem[bus.addr_a];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: next instruction in program order from m_pc.
    logic [7:0] m_pc;
    bit         m_hold, m_flush;
    logic [7:0] s_op, s_imm, s_pc, s_npc;

    always @(posedge clk) begin
        if (rst) begin
            m_hold  = 1'b0;
            m_flush = 1'b0;
        end else begin
            m_hold  = bus.ir_valid && bus.stall && !bus.redirect_valid;
            m_flush = bus.redirect_valid;
            if (bus.redirect_valid) m_pc = bus.redirect_pc;
            s_op  = bus.ir_opcode;
            s_imm = bus.ir_imm;
            s_pc  = bus.ir_pc;
            s_npc = bus.ir_next_pc;
        end
    end

    always @(negedge clk) begin
        logic [7:0] op, imm, p1;
        int len;
        if (!rst) begin
            if (m_flush) begin
                chk("flush_valid", bus.ir_valid, 0);
            end else if (m_hold) begin
                chk("hold_valid", bus.ir_valid, 1);
                chk("hold_op", bus.ir_opcode, s_op);
                chk("hold_imm", bus.ir_imm, s_imm);
                chk("hold_pc", bus.ir_pc, s_pc);
                chk("hold_npc", bus.ir_next_pc, s_npc);
            end else if (bus.ir_valid) begin
                op  = mem[m_pc];
                p1  = m_pc + 8'd1;
                len = (op[7:4] == 4'hC) ? 2 : 1;
                imm = (len == 2) ? mem[p1] : 8'h00;
                chk("m_op", bus.ir_opcode, op);
                chk("m_imm", bus.ir_imm, imm);
                chk("m_pc", bus.ir_pc, m_pc);
                m_pc = m_pc + 8'(len);
                chk("m_npc", bus.ir_next_pc, m_pc);
            end
        end
    end

    task automatic fill();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    endtask

    task automatic do_reset(input logic [7:0] start);
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 8'h00;
        m_pc = start;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.ir_valid, 0);
        chk("rst_op", bus.ir_opcode, 0);
        chk("rst_imm", bus.ir_imm, 0);
        chk("rst_pc", bus.ir_pc, 0);
        chk("rst_npc", bus.ir_next_pc, 0);
        chk("rst_addr", bus.addr_a, 0);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!bus.ir_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, bus.ir_valid, 1);
    endtask

    task automatic mid_reset(input logic [7:0] start);
        @(negedge clk);
        #2 rst = 1'b1;
        m_pc = start;
        #1;
        chk("arst_valid", bus.ir_valid, 0);
        chk("arst_op", bus.ir_opcode, 0);
        chk("arst_pc", bus.ir_pc, 0);
        chk("arst_npc", bus.ir_next_pc, 0);
        chk("arst_addr", bus.addr_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 8'h00;
        fill();
`ifdef RESET_VECTOR_EN
        mem[8'h00] = 8'h80;
        mem[8'h80] = 8'h10;
        do_reset(8'h80);
        chk("vec_req_addr", bus.addr_a, 8'h00);
        @(negedge clk);
        chk("vec_wait_addr", bus.addr_a, 8'h00);
        chk("vec_wait_valid", bus.ir_valid, 0);
        @(negedge clk);
        chk("vec_run_addr", bus.addr_a, 8'h80);
        wait_valid("vec_first");
        chk("vec_op", bus.ir_opcode, 8'h10);
        chk("vec_pc", bus.ir_pc, 8'h80);
        repeat (6) @(negedge clk);
        mid_reset(8'h80);
        chk("vec2_addr", bus.addr_a, 8'h00);
        wait_valid("vec2_first");
        chk("vec2_pc", bus.ir_pc, 8'h80);
        repeat (5) @(negedge clk);
`else
        // Latency and back-to-back 1-byte ops.
        mem[0] = 8'h10;
        mem[1] = 8'h20;
        do_reset(8'h00);
        chk("t1_addr0", bus.addr_a, 8'h00);
        @(negedge clk);
        chk("t1_addr1", bus.addr_a, 8'h01);
        chk("t1_v1", bus.ir_valid, 0);
        @(negedge clk);
        chk("t1_v2", bus.ir_valid, 0);
        @(negedge clk);
        chk("t1_v3", bus.ir_valid, 1);
        chk("t1_op", bus.ir_opcode, 8'h10);
        chk("t1_pc", bus.ir_pc, 8'h00);
        chk("t1_npc", bus.ir_next_pc, 8'h01);
        @(negedge clk);
        chk("t1_op2", bus.ir_opcode, 8'h20);
        chk("t1_pc2", bus.ir_pc, 8'h01);

        // Two-byte op followed by a 1-byte op.
        fill();
        mem[0] = 8'hC1;
        mem[1] = 8'h5A;
        mem[2] = 8'h10;
        do_reset(8'h00);
        wait_valid("t2_first");
        chk("t2_op", bus.ir_opcode, 8'hC1);
        chk("t2_imm", bus.ir_imm, 8'h5A);
        chk("t2_pc", bus.ir_pc, 8'h00);
        chk("t2_npc", bus.ir_next_pc, 8'h02);
        @(negedge clk);
        chk("t2_op2", bus.ir_opcode, 8'h10);
        chk("t2_imm2", bus.ir_imm, 8'h00);
        chk("t2_pc2", bus.ir_pc, 8'h02);

        // Stall fills the FIFO; issue stops at addr 05.
        fill();
        mem[0] = 8'h11;
        do_reset(8'h00);
        wait_valid("t3_first");
        bus.stall = 1'b1;
        repeat (5) @(negedge clk);
        chk("t3_addr_full", bus.addr_a, 8'h05);
        chk("t3_pc_held", bus.ir_pc, 8'h00);
        bus.stall = 1'b0;
        repeat (12) @(negedge clk);

        // Redirect while stalled with C1 at head and 5A in flight.
        fill();
        mem[0] = 8'h10;
        mem[1] = 8'hC1;
        mem[2] = 8'h5A;
        do_reset(8'h00);
        wait_valid("t4_first");
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h40;
        #1 chk("t4_addr_redir", bus.addr_a, 8'h40);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b0;
        chk("t4_flushed", bus.ir_valid, 0);
        wait_valid("t4_new");
        chk("t4_pc", bus.ir_pc, 8'h40);
        repeat (6) @(negedge clk);

        // Redirect to FF: long op wraps into 00.
        mem[8'hFF] = 8'hC2;
        mem[8'h00] = 8'h77;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'hFF;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        wait_valid("t5_first");
        chk("t5_op", bus.ir_opcode, 8'hC2);
        chk("t5_imm", bus.ir_imm, 8'h77);
        chk("t5_pc", bus.ir_pc, 8'hFF);
        chk("t5_npc", bus.ir_next_pc, 8'h01);
        repeat (8) @(negedge clk);

        // Asynchronous reset mid-run, then restart from 00.
        mid_reset(8'h00);
        wait_valid("t6_first");
        chk("t6_pc", bus.ir_pc, 8'h00);
        repeat (5) @(negedge clk);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
